// File: rtl/mem_responder.sv
// Byte-addressed big-endian memory: the far end of the mov/mfc handshake. Optional misalignment fault: MEM_ALIGN_FAULT_EN.
// Latency: LATENCY cycles from request capture to mfc; mfc is held until mov is seen low.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mov,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              mfc,
    output logic              abort
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [31:0]       dout_q, dout_d;
    logic              mfc_q, mfc_d;
    logic              abort_q, abort_d;
    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0] acc_a0, acc_a1, acc_a2, acc_a3;
    logic [31:0]       rdat;
    logic              fault;
    logic              mem_we;

    // Aligned base address; the higher byte lanes are formed by OR-ing in the low bits.
    always_comb begin
        case (size_q)
            2'b00:   acc_a0 = addr_q;
            2'b01:   acc_a0 = {addr_q[ADDR_W-1:1], 1'b0};
            default: acc_a0 = {addr_q[ADDR_W-1:2], 2'b00};
        endcase
    end

    assign acc_a1 = acc_a0 | ADDR_W'(1);
    assign acc_a2 = acc_a0 | ADDR_W'(2);
    assign acc_a3 = acc_a0 | ADDR_W'(3);

    always_comb begin
        case (size_q)
            2'b00:   rdat = {24'h0, mem_q[acc_a0]};
            2'b01:   rdat = {16'h0, mem_q[acc_a0], mem_q[acc_a1]};
            default: rdat = {mem_q[acc_a0], mem_q[acc_a1], mem_q[acc_a2], mem_q[acc_a3]};
        endcase
    end

`ifdef MEM_ALIGN_FAULT_EN
    assign fault = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        wdat_d  = wdat_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        abort_d = abort_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mov) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    size_d  = size;
                    wdat_d  = data_in;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = DONE;
                    mfc_d   = 1'b1;
                    abort_d = fault;
                    if (!fault) begin
                        if (rw_q) dout_d = rdat;
                        else      mem_we = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!mov) begin
                    state_d = IDLE;
                    mfc_d   = 1'b0;
                    abort_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            wdat_q  <= '0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            wdat_q  <= wdat_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            abort_q <= abort_d;
        end
    end

    // Storage is never cleared; reset only cancels a write that would land this edge.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            case (size_q)
                2'b00: mem_q[acc_a0] <= wdat_q[7:0];
                2'b01: begin
                    mem_q[acc_a0] <= wdat_q[15:8];
                    mem_q[acc_a1] <= wdat_q[7:0];
                end
                default: begin
                    mem_q[acc_a0] <= wdat_q[31:24];
                    mem_q[acc_a1] <= wdat_q[23:16];
                    mem_q[acc_a2] <= wdat_q[15:8];
                    mem_q[acc_a3] <= wdat_q[7:0];
                end
            endcase
        end
    end

    assign data_out = dout_q;
    assign mfc      = mfc_q;
    assign abort    = abort_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array model of big-endian memory.
module tb_mem_responder;
    localparam int AW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mov = 1'b0;
    logic          rw = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          mfc;
    logic          abort;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [256];
    logic [31:0] exp_dout = '0;
    logic        exp_abort = 1'b0;

    mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size),
        .addr(addr), .data_in(data_in), .data_out(data_out), .mfc(mfc), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One full handshake. hold = extra cycles mov stays high in DONE; early = drop mov right after capture.
    task automatic access(input logic r, input logic [1:0] sz, input logic [7:0] a,
                          input logic [31:0] d, input int hold, input logic early);
        int n;
        int cyc;
        int ea;
        logic mis;
        logic [31:0] v;
        @(negedge clk);
        mov = 1'b1; rw = r; size = sz; addr = a; data_in = d;
        @(posedge clk);
        #1;
        if (early) mov = 1'b0;
        rw = 1'($urandom); size = 2'($urandom); addr = 8'($urandom); data_in = $urandom;
        cyc = 0;
        while (mfc !== 1'b1 && cyc < 20) begin
            chk("dout_busy", data_out, exp_dout);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, LAT);
        chk("mfc_rise", {31'b0, mfc}, 32'd1);

        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (int'(a) % n) != 0;
`ifdef MEM_ALIGN_FAULT_EN
        exp_abort = mis;
`else
        exp_abort = 1'b0;
        mis = 1'b0;
`endif
        ea = int'(a) - (int'(a) % n);
        if (!mis) begin
            if (r) begin
                v = '0;
                for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mem_m[ea + i]};
                exp_dout = v;
            end else begin
                for (int i = 0; i < n; i++) mem_m[ea + i] = d[8*(n-1-i) +: 8];
            end
        end
        chk("dout_done", data_out, exp_dout);
        chk("abort_done", {31'b0, abort}, {31'b0, exp_abort});

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("mfc_hold", {31'b0, mfc}, 32'd1);
            chk("dout_hold", data_out, exp_dout);
        end
        if (!early) begin
            @(negedge clk);
            mov = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_abort = 1'b0;
        chk("mfc_fall", {31'b0, mfc}, 32'd0);
        chk("abort_fall", {31'b0, abort}, 32'd0);
        chk("dout_after", data_out, exp_dout);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mfc", {31'b0, mfc}, 32'd0);
        chk("rst_abort", {31'b0, abort}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Give the model a known image of 0x00..0x3F.
        for (int w = 0; w < 16; w++) access(1'b0, 2'b10, 8'(4 * w), $urandom, 0, 1'b0);

        access(1'b0, 2'b10, 8'h10, 32'h11223344, 0, 1'b0);
        access(1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0);
        chk("tp_word", data_out, 32'h11223344);
        access(1'b1, 2'b00, 8'h11, 32'h0, 0, 1'b0);
        chk("tp_byte11", data_out, 32'h00000022);
        access(1'b1, 2'b00, 8'h13, 32'h0, 0, 1'b0);
        chk("tp_byte13", data_out, 32'h00000044);
        access(1'b1, 2'b01, 8'h12, 32'h0, 0, 1'b0);
        chk("tp_half12", data_out, 32'h00003344);
        access(1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0);
        access(1'b0, 2'b00, 8'h12, 32'h000000AB, 5, 1'b0);
        access(1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0);
        chk("tp_merge", data_out, 32'h1122AB44);

        // Reset lands on the edge that would have performed the write.
        @(negedge clk);
        mov = 1'b1; rw = 1'b0; size = 2'b10; addr = 8'h20; data_in = 32'hFFFFFFFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mov = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy_mfc", {31'b0, mfc}, 32'd0);
        chk("rst_busy_dout", data_out, 32'd0);
        chk("rst_busy_abort", {31'b0, abort}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_dout = '0;
        access(1'b1, 2'b10, 8'h20, 32'h0, 0, 1'b0);

        access(1'b0, 2'b10, 8'h22, 32'hCAFEF00D, 0, 1'b0);
        access(1'b1, 2'b10, 8'h20, 32'h0, 0, 1'b0);
        access(1'b0, 2'b10, 8'h30, 32'h5A5A0F0F, 0, 1'b1);

        for (int k = 0; k < 300; k++) begin
            logic early;
            int hold;
            early = ($urandom_range(3, 0) == 0);
            hold  = early ? 0 : int'($urandom_range(2, 0));
            access(1'($urandom), 2'($urandom), 8'($urandom_range(63, 0)), $urandom, hold, early);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

- Byte-addressed, big-endian data memory that answers the control unit's memory handshake.
- The control unit raises `mov` with a request and waits for `mfc`; this block is the far end of that handshake.
- It captures the request, waits a fixed latency, performs the read or write, raises `mfc`, and holds it until the control unit withdraws `mov`.
- It sits between the datapath's MAR/MDR outputs and the MDR input mux.

## Interface
- `ADDR_W`, 8: address width; memory depth is 2^ADDR_W bytes.
- `LATENCY`, 2: BUSY cycles between request capture and `mfc`; legal range is 1 or more.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `mov` input 1: memory operation valid, driven by the control unit.
- `rw` input 1: 1 = read, 0 = write.
- `size` input 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- `addr` input ADDR_W: byte address.
- `data_in` input 32: write data, right-justified (byte in [7:0], halfword in [15:0]).
- `data_out` output 32: read data, zero-extended and right-justified; registered.
- `mfc` output 1: memory function complete; registered.
- `abort` output 1: misaligned-access fault; registered; constant 0 unless the macro is enabled.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - When `mov`=1 at an edge: latch `addr`, `rw`, `size` and `data_in` into internal registers.
  - Load the wait counter with LATENCY-1 and go to BUSY.
- **BUSY**
  - Inputs are ignored; only the latched copies are used.
  - Counter ≠ 0: decrement the counter.
  - Counter = 0: perform the access and go to DONE.
- **The access** (performed on the BUSY-to-DONE edge)
  - Write: update the addressed bytes.
  - Read: load `data_out`.
  - On the same edge: `mfc` goes to 1.
- **DONE**
  - `mfc`=1 and `data_out` are held.
  - If `mov`=0 at an edge: `mfc` goes to 0 and the FSM goes to IDLE.
  - If `mov` stays 1: remain in DONE. There is no back-to-back access without `mov` dropping for at least one cycle.
- **Byte order (big-endian)**
  - Word at A: byte A in [31:24], A+1 in [23:16], A+2 in [15:8], A+3 in [7:0].
  - Halfword at A: byte A in [15:8], A+1 in [7:0].
- **Alignment, macro off**
  - Halfword: address bit 0 is forced to 0.
  - Word: address bits [1:0] are forced to 0.
  - Aligned accesses therefore never wrap past the top of memory.
- `data_out` is written only by completed reads and by reset; writes leave it unchanged.
- Memory contents are not cleared by reset.

## Timing
- **Reset** (dominates all other inputs):
  - FSM goes to IDLE.
  - `mfc`=0, `abort`=0, `data_out`=0.
  - Counter is cleared.
  - Any in-flight write is discarded.
- **Latency**: capture at edge E0; `mfc` and the read data are visible after edge E0+LATENCY.
  - With LATENCY=1: `mfc` rises on the edge after capture.
- **Release**: `mfc` falls on the first edge where `mov`=0 in DONE. The earliest next capture is the following edge, if `mov` has returned to 1.
- **`mov` dropped during BUSY**: ignored. The access completes and `mfc` pulses until `mov` is seen low in DONE.
- **Write then read**: a read of the same address issued after the write's `mfc` returns the new data.

## Configuration
- Macro: `MEM_ALIGN_FAULT_EN`.
- **Defined**: a misaligned halfword (addr[0]=1) or word (addr[1:0]≠0) access:
  - follows the normal latency;
  - on the DONE edge, asserts `abort`=1 together with `mfc`=1;
  - performs no memory update;
  - leaves `data_out` unchanged.
  - `abort` clears together with `mfc`.
- **Undefined**: low address bits are silently forced to zero, and `abort` is tied to 0.

## Test plan
- Reset, then write word 0x11223344 to addr 0x10 with LATENCY=2 → `mfc` rises exactly 2 cycles after the capture edge; a read of the word at 0x10 returns 0x11223344.
- Read a byte at 0x11 and at 0x13, and a halfword at 0x12 → `data_out` = 0x00000022, 0x00000044, 0x00003344.
- Write byte 0xAB to 0x12, then read the word at 0x10 → 0x1122AB44; `data_out` stays 0x11223344 between the write's capture and its `mfc`.
- Hold `mov`=1 for 5 cycles after `mfc` → `mfc` stays 1 and no second access occurs; drop `mov` → `mfc`=0 on the next edge, and a new request on the edge after that is accepted.
- Assert `reset` during BUSY of a write of 0xFFFFFFFF to 0x20 → `mfc`=0, `data_out`=0, and a later read of 0x20 returns its prior contents.
- Word write to 0x22:
  - with `MEM_ALIGN_FAULT_EN` defined → `abort`=1 and `mfc`=1, memory unchanged;
  - without the macro → the data lands at 0x20, and `abort` stays 0.
